// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch queue between the PC/IMEM stage and IF/ID
// Ports: clk/rst (sync, active-high); i_flush discards queued and in-flight fetches;
//   i_req_valid/i_req_pc/o_req_ready fetch handshake (memory ce = valid & ready);
//   i_resp_inst memory data MEM_LAT cycles after acceptance;
//   o_pop_valid/i_pop_ready/o_pop_inst/o_pop_pc/o_pop_next_pc head entry to IF/ID;
//   o_count/o_empty/o_full registered occupancy.
// Optional FETCH_QUEUE_BYPASS_EN: a response arriving at an empty queue is
//   presented at the head in the same cycle.
module fetch_queue #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_req_valid,
    input  logic [ADDR_W-1:0]        i_req_pc,
    output logic                     o_req_ready,
    input  logic [DATA_W-1:0]        i_resp_inst,
    output logic                     o_pop_valid,
    input  logic                     i_pop_ready,
    output logic [DATA_W-1:0]        o_pop_inst,
    output logic [ADDR_W-1:0]        o_pop_pc,
    output logic [ADDR_W-1:0]        o_pop_next_pc,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 3;
    logic [MEM_LAT-1:0] r_trk_v;
    logic [ADDR_W-1:0]  r_trk_pc [MEM_LAT];
    logic [DATA_W-1:0]  r_mem_inst [DEPTH];
    logic [ADDR_W-1:0]  r_mem_pc [DEPTH];
    logic [PW-1:0]      r_rptr;
    logic [PW-1:0]      r_wptr;
    logic [CW-1:0]      r_count;
    logic [SW-1:0]      w_inflight;
    logic               w_kill;
    logic               w_accept;
    logic               w_resp_v;
    logic               w_head_v;
    logic               w_byp;
    logic               w_push;
    logic               w_qpop;
    assign w_kill = rst | i_flush;
    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < MEM_LAT; k++) w_inflight = w_inflight + SW'(r_trk_v[k]);
    end
    // reserving a slot for every in-flight fetch means a push can never find the queue full
    assign o_req_ready = !w_kill && ((SW'(r_count) + w_inflight) < SW'(DEPTH));
    assign w_accept    = i_req_valid & o_req_ready;
    assign w_resp_v    = r_trk_v[MEM_LAT-1] & !w_kill;
    assign w_head_v    = (r_count != '0) & !w_kill;
`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_byp = w_resp_v & (r_count == '0);
`else
    assign w_byp = 1'b0;
`endif
    assign o_pop_valid   = w_head_v | w_byp;
    assign w_qpop        = w_head_v & i_pop_ready;
    // a bypassed response taken by IF/ID in the same cycle is never stored
    assign w_push        = w_resp_v & !(w_byp & i_pop_ready);
    assign o_pop_inst    = w_byp ? i_resp_inst : w_head_v ? r_mem_inst[r_rptr] : '0;
    assign o_pop_pc      = w_byp ? r_trk_pc[MEM_LAT-1] : w_head_v ? r_mem_pc[r_rptr] : '0;
    assign o_pop_next_pc = o_pop_pc + ADDR_W'(4);
    assign o_count       = r_count;
    assign o_empty       = r_count == '0;
    assign o_full        = r_count == CW'(DEPTH);
    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_trk_v <= '0;
        end else begin
            r_trk_v[0] <= w_accept;
            for (int k = 1; k < MEM_LAT; k++) r_trk_v[k] <= r_trk_v[k-1];
        end
        r_trk_pc[0] <= rst ? '0 : i_req_pc;
        for (int k = 1; k < MEM_LAT; k++) r_trk_pc[k] <= rst ? '0 : r_trk_pc[k-1];
    end
    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_count <= '0;
            r_rptr  <= '0;
            r_wptr  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_qpop) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_qpop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push && !w_kill) begin
            r_mem_inst[r_wptr] <= i_resp_inst;
            r_mem_pc[r_wptr]   <= r_trk_pc[MEM_LAT-1];
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue at MEM_LAT=1 and MEM_LAT=3
module tb_fetch_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif
    logic        rst, flush, pop_ready, rv1, rv3;
    logic [31:0] req_pc;
    logic        rr1, rr3, pv1, pv3, em1, em3, fu1, fu3;
    logic [31:0] ri1, ri3, pi1, pi3, pp1, pp3, pn1, pn3;
    logic [2:0]  cnt1, cnt3;
    logic [31:0] m1;
    logic [31:0] m3 [3];
    logic [31:0] exp_q [$];
    int tests = 0;
    int fails = 0;
    int lat;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) begin
        m1    <= req_pc;
        m3[0] <= req_pc;
        m3[1] <= m3[0];
        m3[2] <= m3[1];
    end
    assign ri1 = inst_of(m1);
    assign ri3 = inst_of(m3[2]);

    fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .MEM_LAT(1)) u1 (
        .clk(clk), .rst(rst), .i_flush(flush), .i_req_valid(rv1), .i_req_pc(req_pc),
        .o_req_ready(rr1), .i_resp_inst(ri1), .o_pop_valid(pv1), .i_pop_ready(pop_ready),
        .o_pop_inst(pi1), .o_pop_pc(pp1), .o_pop_next_pc(pn1), .o_count(cnt1),
        .o_empty(em1), .o_full(fu1));
    fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .MEM_LAT(3)) u3 (
        .clk(clk), .rst(rst), .i_flush(flush), .i_req_valid(rv3), .i_req_pc(req_pc),
        .o_req_ready(rr3), .i_resp_inst(ri3), .o_pop_valid(pv3), .i_pop_ready(pop_ready),
        .o_pop_inst(pi3), .o_pop_pc(pp3), .o_pop_next_pc(pn3), .o_count(cnt3),
        .o_empty(em3), .o_full(fu3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] npc);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s unexpected pop: got pc %h expected no pop", tag, pc);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " pop_pc"}, pc, e);
            chk({tag, " pop_inst"}, inst, inst_of(e));
            chk({tag, " pop_next_pc"}, npc, e + 32'd4);
        end
    endtask

    always @(negedge clk) begin
        if (pv1 && pop_ready) mon("u1", pp1, pi1, pn1);
        if (pv3 && pop_ready) mon("u3", pp3, pi3, pn3);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input bit sel3, input logic [31:0] pc, input bit keep);
        bit ok = 1'b0;
        req_pc = pc;
        if (sel3) rv3 = 1'b1;
        else rv1 = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = sel3 ? rr3 : rr1;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL issue %h: got no accept, expected accept within 40 cycles", pc);
        end else if (keep) begin
            exp_q.push_back(pc);
        end
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 30 && exp_q.size() != 0; n++) cyc(1);
        cyc(4);
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " pop_valid"}, pv1, 0);
        chk({tag, " pop_inst"}, pi1, 0);
        chk({tag, " pop_pc"}, pp1, 0);
        chk({tag, " pop_next_pc"}, pn1, 4);
        chk({tag, " count"}, cnt1, 0);
        chk({tag, " empty"}, em1, 1);
        chk({tag, " full"}, fu1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; pop_ready = 1'b0; rv1 = 1'b0; rv3 = 1'b0; req_pc = '0;
        cyc(2);
        @(negedge clk);
        chk("rst req_ready u1", rr1, 0);
        chk("rst req_ready u3", rr3, 0);
        chk_reset_vals("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("post-rst");
        @(posedge clk); #1;
        // in-order pops and request-to-visible latency
        pop_ready = 1'b1;
        issue(0, 32'h0, 1);
        rv1 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!pv1 && lat < 10);
        chk("latency", lat, EXP_LAT);
        @(posedge clk); #1;
        issue(0, 32'h4, 1);
        issue(0, 32'h8, 1);
        rv1 = 1'b0;
        drain("drain basic");
        // fill with IF/ID stalled: credit stops at 4
        pop_ready = 1'b0;
        issue(0, 32'h10, 1);
        issue(0, 32'h14, 1);
        issue(0, 32'h18, 1);
        issue(0, 32'h1C, 1);
        rv1 = 1'b1;
        req_pc = 32'h20;
        cyc(2);
        @(negedge clk);
        chk("full req_ready", rr1, 0);
        chk("full count", cnt1, 4);
        chk("full flag", fu1, 1);
        chk("full empty", em1, 0);
        // one pop at full, then the pending request refills across the wrap
        @(posedge clk); #1;
        pop_ready = 1'b1;
        @(posedge clk); #1;
        pop_ready = 1'b0;
        issue(0, 32'h20, 1);
        rv1 = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("refill count", cnt1, 4);
        chk("refill full", fu1, 1);
        @(posedge clk); #1;
        pop_ready = 1'b1;
        drain("drain wrap");
        // flush with three queued entries and IF/ID ready
        pop_ready = 1'b0;
        issue(0, 32'h30, 1);
        issue(0, 32'h34, 1);
        issue(0, 32'h38, 1);
        rv1 = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("pre-flush count", cnt1, 3);
        @(posedge clk); #1;
        pop_ready = 1'b1;
        flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("flush pop_valid", pv1, 0);
        chk("flush req_ready", rr1, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("post-flush count", cnt1, 0);
        chk("post-flush empty", em1, 1);
        chk("post-flush pop_valid", pv1, 0);
        chk("post-flush pop_inst", pi1, 0);
        @(posedge clk); #1;
        cyc(3);
        // reset in the middle of a stream
        pop_ready = 1'b0;
        issue(0, 32'h40, 0);
        issue(0, 32'h44, 0);
        req_pc = 32'h48;
        rst = 1'b1;
        @(negedge clk);
        chk("mid-rst req_ready", rr1, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rv1 = 1'b0;
        @(negedge clk);
        chk_reset_vals("mid-rst");
        @(posedge clk); #1;
        pop_ready = 1'b1;
        cyc(3);
        chk("mid-rst stale count", cnt1, 0);
        issue(0, 32'h50, 1);
        issue(0, 32'h54, 1);
        rv1 = 1'b0;
        drain("drain restart");
        // MEM_LAT=3: flush while two fetches are in flight
        issue(1, 32'h100, 0);
        issue(1, 32'h104, 0);
        rv3 = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("u3 flush req_ready", rr3, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        issue(1, 32'h200, 1);
        rv3 = 1'b0;
        drain("drain u3");
        @(negedge clk);
        chk("u3 count", cnt3, 0);
        chk("u3 empty", em3, 1);
        chk("u3 full", fu3, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
